// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for the up_down_counter: latches a sweep command, drives the
// counter's load/enable/direction pins and stops at the border or terminal count.
module counter_sweep_ctrl #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] cfg_begpoint,
  input  logic [WIDTH-1:0] cfg_border,
  input  logic             cfg_up,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_repeat,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic [WIDTH-1:0] cnt_begpoint,
  output logic             busy,
  output logic             done,
  output logic             hit_border,
  output logic [LEN_W-1:0] elapsed
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] beg_q, beg_d;
  logic [WIDTH-1:0] border_q, border_d;
  logic             up_q, up_d;
  logic             rpt_q, rpt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] elapsed_q, elapsed_d;
  logic             hit_q, hit_d;
  logic             at_border;
  logic             at_len;
  logic             stop;

  always_comb begin
    state_d   = state_q;
    beg_d     = beg_q;
    border_d  = border_q;
    up_d      = up_q;
    rpt_d     = rpt_q;
    len_d     = len_q;
    elapsed_d = elapsed_q;
    hit_d     = hit_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    done      = 1'b0;

    at_border = (cnt_value == border_q);
    at_len    = (len_q != '0) && (elapsed_q == len_q);
    stop      = at_border || at_len;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          beg_d    = cfg_begpoint;
          border_d = cfg_border;
          up_d     = cfg_up;
          rpt_d    = cfg_repeat;
          len_d    = cfg_len;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_load  = 1'b1;
          elapsed_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (stop) begin
          hit_d   = at_border;
          state_d = S_DONE;
        end else begin
          cnt_en    = 1'b1;
          elapsed_d = elapsed_q + LEN_W'(1);
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          done    = 1'b1;
          state_d = rpt_q ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset outranks everything: strobes drop in the reset cycle so the counter holds.
    if (reset) begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beg_q     <= '0;
      border_q  <= '0;
      up_q      <= 1'b0;
      rpt_q     <= 1'b0;
      len_q     <= '0;
      elapsed_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beg_q     <= beg_d;
      border_q  <= border_d;
      up_q      <= up_d;
      rpt_q     <= rpt_d;
      len_q     <= len_d;
      elapsed_q <= elapsed_d;
      hit_q     <= hit_d;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign busy         = !ready;
  assign cnt_up       = up_q;
  assign cnt_begpoint = beg_q;
  assign hit_border   = hit_q;
  assign elapsed      = elapsed_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural up/down counter closes the loop and
// a sweep-level reference model predicts enable counts, end values and timing.
module tb_counter_sweep_ctrl;
  localparam int W  = 16;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_up = 1'b0;
  logic          cfg_repeat = 1'b0;
  logic [W-1:0]  cfg_begpoint = '0;
  logic [W-1:0]  cfg_border = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [W-1:0]  cnt_value = '0;
  logic [W-1:0]  cnt_begpoint;
  logic [LW-1:0] elapsed;
  logic          ready, cnt_load, cnt_en, cnt_up, busy, done, hit_border;

  int checks = 0;
  int fails = 0;
  int n_load = 0, n_en = 0, n_done = 0, n_overlap = 0;

  counter_sweep_ctrl #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .cfg_begpoint(cfg_begpoint), .cfg_border(cfg_border), .cfg_up(cfg_up),
    .cfg_len(cfg_len), .cfg_repeat(cfg_repeat), .abort(abort),
    .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_up(cnt_up),
    .cnt_begpoint(cnt_begpoint), .busy(busy), .done(done),
    .hit_border(hit_border), .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  // Registered up/down counter the sequencer is meant to drive.
  always @(posedge clk) begin
    if (cnt_load)    cnt_value <= cnt_begpoint;
    else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 1'b1 : cnt_value - 1'b1;
  end

  always @(negedge clk) begin
    n_load += int'(cnt_load);
    n_en   += int'(cnt_en);
    n_done += int'(done);
    if (cnt_load && cnt_en) n_overlap++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Enabled cycles for a sweep: first step count at which the border or the length is met.
  function automatic int model_n(input logic [W-1:0] beg, input logic [W-1:0] border,
                                 input logic up, input int len);
    logic [W-1:0] v;
    for (int k = 0; k < 70000; k++) begin
      v = up ? beg + W'(k) : beg - W'(k);
      if (v == border) return k;
      if (len != 0 && k == len) return k;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] model_val(input logic [W-1:0] beg, input logic up, input int n);
    return up ? beg + W'(n) : beg - W'(n);
  endfunction

  task automatic do_sweep(input string nm, input logic [W-1:0] beg, input logic [W-1:0] border,
                          input logic up, input logic [LW-1:0] len);
    int n, c, l0, e0, d0;
    logic [W-1:0] ev;
    logic eh;
    n  = model_n(beg, border, up, int'(len));
    ev = model_val(beg, up, n);
    eh = (ev == border);
    cfg_begpoint = beg; cfg_border = border; cfg_up = up; cfg_len = len; cfg_repeat = 1'b0;
    l0 = n_load; e0 = n_en; d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 1;
    while (!done && c < 300) begin
      tick;
      c++;
    end
    checks++;
    if (c != n + 3) begin fails++; $display("FAIL %s done_latency got %0d want %0d", nm, c, n + 3); end
    checks++;
    if (cnt_value !== ev) begin fails++; $display("FAIL %s end_value got %0d want %0d", nm, cnt_value, ev); end
    tick;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL %s ready_after_done got %b want 1", nm, ready); end
    checks++;
    if (hit_border !== eh) begin fails++; $display("FAIL %s hit_border got %b want %b", nm, hit_border, eh); end
    checks++;
    if (elapsed !== LW'(n)) begin fails++; $display("FAIL %s elapsed got %0d want %0d", nm, elapsed, n); end
    checks++;
    if (n_en - e0 != n) begin fails++; $display("FAIL %s en_cycles got %0d want %0d", nm, n_en - e0, n); end
    checks++;
    if (n_load - l0 != 1) begin fails++; $display("FAIL %s load_pulses got %0d want 1", nm, n_load - l0); end
    checks++;
    if (n_done - d0 != 1) begin fails++; $display("FAIL %s done_pulses got %0d want 1", nm, n_done - d0); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    checks++;
    if ({ready, busy, cnt_load, cnt_en, cnt_up, done, hit_border} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {ready, busy, cnt_load, cnt_en, cnt_up, done, hit_border});
    end
    checks++;
    if (elapsed !== '0 || cnt_begpoint !== '0) begin
      fails++; $display("FAIL reset_data got elapsed=%0d beg=%0d want 0/0", elapsed, cnt_begpoint);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", ready); end
  endtask

  task automatic test_directed;
    do_sweep("t1_len_stop", 16'd432, 16'd0, 1'b1, 6'd44);
    do_sweep("t2_wrap_border", 16'd65525, 16'd5, 1'b1, 6'd0);
    do_sweep("t3_beg_eq_border", 16'd10, 16'd10, 1'b0, 6'd20);
    do_sweep("both_together", 16'd50, 16'd45, 1'b0, 6'd5);
    do_sweep("down_wrap", 16'd3, 16'd65530, 1'b0, 6'd0);
  endtask

  task automatic test_idle_abort;
    int l0;
    logic hb;
    l0 = n_load; hb = hit_border;
    cfg_begpoint = 16'd7; cfg_border = 16'd9; cfg_up = 1'b1; cfg_len = 6'd0;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    tick;
    checks++;
    if (ready !== 1'b1 || n_load != l0) begin
      fails++; $display("FAIL idle_abort_start got ready=%b loads=%0d want 1/0", ready, n_load - l0);
    end
    checks++;
    if (hit_border !== hb) begin fails++; $display("FAIL idle_abort_hit got %b want %b", hit_border, hb); end
  endtask

  task automatic test_repeat;
    int loads[$];
    int dn, c;
    logic prev_load;
    int l0, d0;
    cfg_begpoint = 16'd0; cfg_border = 16'd1000; cfg_up = 1'b1; cfg_len = 6'd40; cfg_repeat = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_repeat = 1'b0;
    dn = 0; prev_load = 1'b0;
    for (c = 1; c <= 140; c++) begin
      if (prev_load) begin
        checks++;
        if (cnt_value !== 16'd0) begin fails++; $display("FAIL rpt_start_value got %0d want 0", cnt_value); end
      end
      if (cnt_load) loads.push_back(c);
      prev_load = cnt_load;
      if (done) begin
        dn++;
        checks++;
        if (cnt_value !== 16'd40) begin fails++; $display("FAIL rpt_end_value got %0d want 40", cnt_value); end
      end
      tick;
    end
    checks++;
    if (loads.size() != 4 || dn != 3) begin
      fails++; $display("FAIL rpt_counts got loads=%0d dones=%0d want 4/3", loads.size(), dn);
    end
    for (int i = 1; i < loads.size(); i++) begin
      checks++;
      if (loads[i] - loads[i-1] != 43) begin
        fails++; $display("FAIL rpt_period got %0d want 43", loads[i] - loads[i-1]);
      end
    end
    abort = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
      fails++; $display("FAIL rpt_abort_strobes got en=%b load=%b want 0/0", cnt_en, cnt_load);
    end
    tick;
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL rpt_abort_ready got %b want 1", ready); end
    l0 = n_load; d0 = n_done;
    repeat (60) tick;
    checks++;
    if (n_load != l0 || n_done != d0) begin
      fails++; $display("FAIL rpt_after_abort got loads=%0d dones=%0d want 0/0", n_load - l0, n_done - d0);
    end
  endtask

  task automatic test_cancel(input logic use_reset);
    int c, d0;
    string nm;
    nm = use_reset ? "t5_reset" : "t5_abort";
    cfg_begpoint = 16'd100; cfg_border = 16'd0; cfg_up = 1'b0; cfg_len = 6'd0; cfg_repeat = 1'b0;
    d0 = n_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    c = 0;
    while (elapsed !== 6'd7 && c < 50) begin
      tick;
      c++;
    end
    checks++;
    if (c >= 50) begin fails++; $display("FAIL %s reach_elapsed7 got timeout want elapsed=7", nm); end
    if (use_reset) reset = 1'b1;
    else           abort = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0) begin fails++; $display("FAIL %s en_same_cycle got %b want 0", nm, cnt_en); end
    tick;
    reset = 1'b0; abort = 1'b0;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL %s ready_next got %b want 1", nm, ready); end
    repeat (5) tick;
    checks++;
    if (cnt_value !== 16'd93) begin fails++; $display("FAIL %s held_value got %0d want 93", nm, cnt_value); end
    checks++;
    if (n_done != d0) begin fails++; $display("FAIL %s no_done got %0d want 0", nm, n_done - d0); end
  endtask

  task automatic test_start_while_busy;
    int c, l0;
    cfg_begpoint = 16'd200; cfg_border = 16'd0; cfg_up = 1'b1; cfg_len = 6'd10; cfg_repeat = 1'b0;
    l0 = n_load;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    cfg_begpoint = 16'd5; cfg_len = 6'd3; cfg_up = 1'b0; cfg_border = 16'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 4;
    while (!done && c < 300) begin
      tick;
      c++;
    end
    checks++;
    if (c != 13) begin fails++; $display("FAIL t6_latency got %0d want 13", c); end
    tick;
    checks++;
    if (cnt_value !== 16'd210) begin fails++; $display("FAIL t6_end_value got %0d want 210", cnt_value); end
    checks++;
    if (cnt_begpoint !== 16'd200 || n_load - l0 != 1) begin
      fails++; $display("FAIL t6_shadow got beg=%0d loads=%0d want 200/1", cnt_begpoint, n_load - l0);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] beg, border;
    logic up;
    logic [LW-1:0] len;
    int d;
    for (int i = 0; i < 12; i++) begin
      beg = W'($urandom);
      up  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(0, 50);
        border = up ? beg + W'(d) : beg - W'(d);
        len = LW'($urandom_range(0, 63));
      end else begin
        border = up ? beg - 1'b1 : beg + 1'b1;
        len = LW'($urandom_range(1, 63));
      end
      do_sweep("random", beg, border, up, len);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_abort();
    test_repeat();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_start_while_busy();
    test_random();
    checks++;
    if (n_overlap != 0) begin fails++; $display("FAIL load_en_overlap got %0d want 0", n_overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
